// File: rtl/count_event_fifo.sv
// count_event_fifo
// Observes the output of a mod-(MAX_CNT+1) up/down counter, classifies every
// sampled transition and queues the non-trivial ones (wrap, jump, illegal) as
// timestamped records in a small FIFO drained over a valid/ready handshake.
// Records that find the FIFO full (and no pop on the same edge) are dropped
// and counted in a saturating counter.
//
// Ports
//   clock     in   rising-edge clock
//   resetn    in   asynchronous active-low reset
//   count     in   counter value, sampled every edge
//   drop_clr  in   synchronous clear of drop_cnt
//   ev_ready  in   consumer accepts the head record
//   ev_valid  out  FIFO non-empty
//   ev_data   out  head record {code[1:0], prev[3:0], cur[3:0], ts}
//   level     out  FIFO occupancy
//   drop_cnt  out  saturating count of dropped records
module count_event_fifo #(
   parameter int unsigned DEPTH   = 4,
   parameter int unsigned TS_W    = 8,
   parameter int unsigned MAX_CNT = 10
) (
   input  logic                      clock,
   input  logic                      resetn,
   input  logic [3:0]                count,
   input  logic                      drop_clr,
   input  logic                      ev_ready,
   output logic                      ev_valid,
   output logic [10+TS_W-1:0]        ev_data,
   output logic [$clog2(DEPTH):0]    level,
   output logic [7:0]                drop_cnt
);

   localparam int unsigned PTR_W = $clog2(DEPTH);
   localparam int unsigned LVL_W = PTR_W + 1;
   localparam int unsigned REC_W = 10 + TS_W;

   localparam logic [3:0] MAX_V = 4'(MAX_CNT);

   localparam logic [1:0] CODE_WRAP_UP   = 2'd0;
   localparam logic [1:0] CODE_WRAP_DOWN = 2'd1;
   localparam logic [1:0] CODE_JUMP      = 2'd2;
   localparam logic [1:0] CODE_ILLEGAL   = 2'd3;

   // ---------------------------------------------------------------------
   // State
   // ---------------------------------------------------------------------
   logic [3:0]       smp_q,       smp_d;
   logic             have_prev_q, have_prev_d;
   logic [TS_W-1:0]  ts_q,        ts_d;
   logic [PTR_W-1:0] wr_ptr_q,    wr_ptr_d;
   logic [PTR_W-1:0] rd_ptr_q,    rd_ptr_d;
   logic [LVL_W-1:0] level_q,     level_d;
   logic [7:0]       drop_cnt_q,  drop_cnt_d;
   logic [REC_W-1:0] mem_q [DEPTH];

   // ---------------------------------------------------------------------
   // Classification
   // ---------------------------------------------------------------------
   logic [3:0]       prev_c;
   logic [3:0]       cur_c;
   logic [4:0]       prev_inc_c;
   logic [4:0]       prev_dec_c;
   logic             step_ok_c;
   logic             event_c;
   logic [1:0]       code_c;
   logic [REC_W-1:0] rec_c;

   assign prev_c = smp_q;
   assign cur_c  = count;

   // Extended by one bit so that 15+1 and 0-1 never alias a real value.
   assign prev_inc_c = {1'b0, prev_c} + 5'd1;
   assign prev_dec_c = {1'b0, prev_c} - 5'd1;

   // Priority-ordered classifier; no event until the first sample exists.
   always_comb begin
      event_c   = 1'b0;
      code_c    = CODE_JUMP;
      step_ok_c = (cur_c == prev_c)
               || ({1'b0, cur_c} == prev_inc_c)
               || ({1'b0, cur_c} == prev_dec_c);
      if (have_prev_q) begin
         if ((cur_c > MAX_V) || (prev_c > MAX_V)) begin
            event_c = 1'b1;
            code_c  = CODE_ILLEGAL;
         end else if ((prev_c == MAX_V) && (cur_c == 4'd0)) begin
            event_c = 1'b1;
            code_c  = CODE_WRAP_UP;
         end else if ((prev_c == 4'd0) && (cur_c == MAX_V)) begin
            event_c = 1'b1;
            code_c  = CODE_WRAP_DOWN;
         end else if (!step_ok_c) begin
            event_c = 1'b1;
            code_c  = CODE_JUMP;
         end
      end
   end

   // Timestamp is the value before this edge's increment.
   assign rec_c = {code_c, prev_c, cur_c, ts_q};

   // ---------------------------------------------------------------------
   // FIFO control
   // ---------------------------------------------------------------------
   logic full_c;
   logic pop_c;
   logic push_c;
   logic drop_c;

   assign full_c = (level_q == LVL_W'(DEPTH));
   assign pop_c  = ev_valid && ev_ready;
   // A full FIFO still takes the record when the head leaves on this edge.
   assign push_c = event_c && (!full_c || pop_c);
   assign drop_c = event_c && full_c && !pop_c;

   // Next-state logic for sampler, timestamp, pointers, level and drop count.
   always_comb begin
      smp_d       = count;
      have_prev_d = 1'b1;
      ts_d        = ts_q + TS_W'(1);
      wr_ptr_d    = wr_ptr_q;
      rd_ptr_d    = rd_ptr_q;
      level_d     = level_q;
      drop_cnt_d  = drop_cnt_q;

      if (push_c) begin
         wr_ptr_d = wr_ptr_q + PTR_W'(1);
      end
      if (pop_c) begin
         rd_ptr_d = rd_ptr_q + PTR_W'(1);
      end
      if (push_c && !pop_c) begin
         level_d = level_q + LVL_W'(1);
      end else if (!push_c && pop_c) begin
         level_d = level_q - LVL_W'(1);
      end

      // Clear wins over accumulation, but a drop on the same edge still counts.
      if (drop_clr) begin
         drop_cnt_d = drop_c ? 8'd1 : 8'd0;
      end else if (drop_c && (drop_cnt_q != 8'hFF)) begin
         drop_cnt_d = drop_cnt_q + 8'd1;
      end
   end

   // Control state register.
   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) begin
         smp_q       <= '0;
         have_prev_q <= 1'b0;
         ts_q        <= '0;
         wr_ptr_q    <= '0;
         rd_ptr_q    <= '0;
         level_q     <= '0;
         drop_cnt_q  <= '0;
      end else begin
         smp_q       <= smp_d;
         have_prev_q <= have_prev_d;
         ts_q        <= ts_d;
         wr_ptr_q    <= wr_ptr_d;
         rd_ptr_q    <= rd_ptr_d;
         level_q     <= level_d;
         drop_cnt_q  <= drop_cnt_d;
      end
   end

   // Record storage; contents are invalidated by the pointer/level reset.
   always_ff @(posedge clock) begin
      if (push_c) begin
         mem_q[wr_ptr_q] <= rec_c;
      end
   end

   // ---------------------------------------------------------------------
   // Outputs
   // ---------------------------------------------------------------------
   assign ev_valid = (level_q != '0);
   // Masked so stale storage never shows while empty or in reset.
   assign ev_data  = ev_valid ? mem_q[rd_ptr_q] : '0;
   assign level    = level_q;
   assign drop_cnt = drop_cnt_q;

endmodule

// File: tb/tb_count_event_fifo.sv
// Testbench for count_event_fifo: directed scenarios followed by randomized
// traffic, all checked against a queue-based reference model.
module tb_count_event_fifo;

   localparam int DEPTH   = 4;
   localparam int TS_W    = 8;
   localparam int MAX_CNT = 10;

   logic        clock;
   logic        resetn;
   logic [3:0]  count;
   logic        drop_clr;
   logic        ev_ready;
   logic        ev_valid;
   logic [17:0] ev_data;
   logic [2:0]  level;
   logic [7:0]  drop_cnt;

   count_event_fifo #(.DEPTH(DEPTH), .TS_W(TS_W), .MAX_CNT(MAX_CNT)) dut (
      .clock    (clock),
      .resetn   (resetn),
      .count    (count),
      .drop_clr (drop_clr),
      .ev_ready (ev_ready),
      .ev_valid (ev_valid),
      .ev_data  (ev_data),
      .level    (level),
      .drop_cnt (drop_cnt)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   int n_checks = 0;
   int n_errors = 0;

   // Reference model state
   logic [17:0] mq[$];
   int          m_ts;
   int          m_prev;
   bit          m_have_prev;
   int          m_drop;

   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   function automatic logic [17:0] mk_rec(input int code, input int p, input int c, input int ts);
      logic [17:0] r;
      r = {2'(code), 4'(p), 4'(c), 8'(ts)};
      return r;
   endfunction

   // Returns -1 for "no event", otherwise the record code.
   function automatic int classify(input int p, input int c);
      if (c > MAX_CNT || p > MAX_CNT)      return 3;
      if (p == MAX_CNT && c == 0)          return 0;
      if (p == 0 && c == MAX_CNT)          return 1;
      if (c == p || c == p + 1 || c == p - 1) return -1;
      return 2;
   endfunction

   task automatic model_reset();
      mq.delete();
      m_ts        = 0;
      m_prev      = 0;
      m_have_prev = 0;
      m_drop      = 0;
   endtask

   // Applies one clock edge to the model using the inputs driven before it.
   task automatic model_edge(input int c, input bit rdy, input bit clr);
      bit pop;
      bit drop;
      int code;
      pop  = (mq.size() > 0) && rdy;
      drop = 0;
      code = m_have_prev ? classify(m_prev, c) : -1;
      if (pop) void'(mq.pop_front());
      if (code >= 0) begin
         if (mq.size() < DEPTH) mq.push_back(mk_rec(code, m_prev, c, m_ts));
         else                   drop = 1;
      end
      if (clr)       m_drop = drop ? 1 : 0;
      else if (drop) m_drop = (m_drop < 255) ? m_drop + 1 : 255;
      m_ts        = (m_ts + 1) % 256;
      m_prev      = c;
      m_have_prev = 1;
   endtask

   task automatic check_outputs(input string tag);
      check_val({tag, ".valid"}, 32'(ev_valid), 32'(mq.size() > 0));
      check_val({tag, ".level"}, 32'(level), 32'(mq.size()));
      check_val({tag, ".drop"},  32'(drop_cnt), 32'(m_drop));
      check_val({tag, ".data"},  32'(ev_data), (mq.size() > 0) ? 32'(mq[0]) : 32'd0);
   endtask

   // One cycle: drive inputs, take the edge, update model, sample 1ns later.
   task automatic step(input string tag, input int c, input bit rdy, input bit clr);
      count    = 4'(c);
      ev_ready = rdy;
      drop_clr = clr;
      @(posedge clock);
      model_edge(c, rdy, clr);
      #1;
      check_outputs(tag);
   endtask

   // Asynchronous reset pulse placed between edges.
   task automatic pulse_reset(input string tag);
      resetn = 1'b0;
      #2;
      model_reset();
      check_val({tag, ".rst_valid"}, 32'(ev_valid), 32'd0);
      check_val({tag, ".rst_level"}, 32'(level), 32'd0);
      check_val({tag, ".rst_drop"},  32'(drop_cnt), 32'd0);
      check_val({tag, ".rst_data"},  32'(ev_data), 32'd0);
      #1;
      resetn = 1'b1;
   endtask

   initial begin
      int cur;
      int r;
      resetn   = 1'b0;
      count    = 4'd0;
      drop_clr = 1'b0;
      ev_ready = 1'b0;
      model_reset();
      #3;
      check_val("init.valid", 32'(ev_valid), 32'd0);
      check_val("init.level", 32'(level), 32'd0);
      check_val("init.drop",  32'(drop_cnt), 32'd0);
      check_val("init.data",  32'(ev_data), 32'd0);
      @(negedge clock);
      resetn = 1'b1;

      // Wrap up: 8,9,10,0 -> one record {0,10,0,ts=3}
      step("wu0", 8, 1, 0);
      step("wu1", 9, 1, 0);
      step("wu2", 10, 1, 0);
      check_val("wu2.novalid", 32'(ev_valid), 32'd0);
      step("wu3", 0, 1, 0);
      check_val("wu3.rec", 32'(ev_data), 32'(mk_rec(0, 10, 0, 3)));

      // Wrap down: 1,0,10,9 -> one record {1,0,10}
      step("wd0", 1, 1, 0);
      step("wd1", 0, 1, 0);
      step("wd2", 10, 1, 0);
      check_val("wd2.rec", 32'(ev_data), 32'(mk_rec(1, 0, 10, 6)));
      step("wd3", 9, 1, 0);
      check_val("wd3.novalid", 32'(ev_valid), 32'd0);

      // Load jump then illegal on consecutive cycles
      pulse_reset("ji");
      step("ji0", 3, 1, 0);
      step("ji1", 7, 1, 0);
      check_val("ji1.rec", 32'(ev_data), 32'(mk_rec(2, 3, 7, 1)));
      step("ji2", 12, 1, 0);
      check_val("ji2.rec", 32'(ev_data), 32'(mk_rec(3, 7, 12, 2)));
      step("ji3", 12, 1, 0);

      // Overflow: 6 jumps with consumer stalled
      pulse_reset("ov");
      step("ov0", 0, 0, 0);
      for (int i = 0; i < 6; i++) step("ovj", (i % 2 == 0) ? 5 : 0, 0, 0);
      check_val("ov.level", 32'(level), 32'd4);
      check_val("ov.drop",  32'(drop_cnt), 32'd2);
      check_val("ov.head",  32'(ev_data), 32'(mk_rec(2, 0, 5, 1)));
      step("ovclr", 0, 0, 1);
      check_val("ovclr.drop", 32'(drop_cnt), 32'd0);
      for (int i = 0; i < 4; i++) step("ovpop", 0, 1, 0);
      check_val("ov.empty", 32'(ev_valid), 32'd0);

      // Full with simultaneous push and pop
      pulse_reset("fp");
      step("fp0", 0, 0, 0);
      for (int i = 0; i < 4; i++) step("fpj", (i % 2 == 0) ? 5 : 0, 0, 0);
      step("fpx", 5, 1, 0);
      check_val("fpx.level", 32'(level), 32'd4);
      check_val("fpx.drop",  32'(drop_cnt), 32'd0);

      // Reset mid-operation with two entries queued
      pulse_reset("rm");
      step("rm0", 2, 0, 0);
      step("rm1", 6, 0, 0);
      step("rm2", 1, 0, 0);
      check_val("rm.level2", 32'(level), 32'd2);
      pulse_reset("rmr");
      step("rm3", 5, 0, 0);
      check_val("rm3.novalid", 32'(ev_valid), 32'd0);
      step("rm4", 9, 0, 0);
      check_val("rm4.rec", 32'(ev_data), 32'(mk_rec(2, 5, 9, 1)));

      // Randomized traffic: mostly counter-like steps, some loads and illegal values
      cur = 9;
      for (int i = 0; i < 400; i++) begin
         r = $urandom_range(0, 9);
         if (r < 6)      cur = (cur > MAX_CNT) ? 0 : (cur + $urandom_range(0, 2) + MAX_CNT) % (MAX_CNT + 1);
         else if (r < 9) cur = $urandom_range(0, MAX_CNT);
         else            cur = $urandom_range(0, 15);
         if ($urandom_range(0, 99) == 0) pulse_reset("rnd");
         step("rnd", cur, 1'($urandom_range(0, 3) != 0 ? ($urandom_range(0, 1)) : 0),
              1'($urandom_range(0, 19) == 0));
      end

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
